// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the data-memory controller state encoding.
package cpu_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ctrlState_t;
endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller behind the MEM stage: issues one access at a time over a
// valid/ack handshake, stalls the pipeline while it is in flight and returns load data.
module dmem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic [15:0]       stall_cycles
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ctrlState_t       state;
  ctrlState_t       nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             req;
  logic             issue;
  logic             misalignHit;
  logic             timeoutHit;

  assign req = (mem_read | mem_write) & ~flush;

  // Next-state decode plus the handshake/stall outputs that must react within the cycle
  always_comb begin
    nextState    = state;
    stall        = 1'b0;
    mem_req      = 1'b0;
    issue        = 1'b0;
    misalignHit  = 1'b0;
    timeoutHit   = 1'b0;
    err_misalign = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!addr[0]) begin
            issue     = 1'b1;
            stall     = 1'b1;
            nextState = BUSY;
          end else begin
            misalignHit = 1'b1;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          nextState = DONE;
        end else if (waitCnt == CNT_LAST) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    err_misalign = misalignHit;
    if (rst) begin
      stall        = 1'b0;
      mem_req      = 1'b0;
      err_misalign = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      waitCnt      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      data_out     <= '0;
      err_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= nextState;
      if (issue) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_we    <= mem_write;
        waitCnt   <= '0;
      end
      if (state == BUSY) begin
        if (mem_ack) begin
          data_out <= mem_we ? '0 : mem_rdata;
        end else begin
          waitCnt <= waitCnt + CNT_W'(1);
        end
      end
      if (timeoutHit) begin
        err_timeout <= 1'b1;
        data_out    <= '0;
      end
      if (misalignHit) begin
        data_out <= '0;
      end
      // Free-running wrap is intentional: software reads the delta between samples
      if (stall) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule
